// File: rtl/filter_cycle_scheduler_pkg.sv
// Shared types for the filtration-loop pump sequencer: state and fault
// encodings, the duty width, and a decode helper for ramp-driven states.
package filter_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILLING   = 3'd1,
    S_RETURNING = 3'd2,
    S_DRAINING  = 3'd3,
    S_DEADTIME  = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    F_NONE     = 2'b00,
    F_FILL     = 2'b01,
    F_DRAIN    = 2'b10,
    F_CONFLICT = 2'b11
  } fault_t;

  // States in which the shared ramp is routed to a pump and advances.
  function automatic logic is_pump_state(input state_t s);
    return (s == S_FILLING) || (s == S_RETURNING) || (s == S_DRAINING);
  endfunction

endpackage

// File: rtl/filter_cycle_scheduler_if.sv
// Bundle of the sequencer's status, sensor and pump-duty signals.
// The slave side is the scheduler; the master side is its environment.
interface filter_cycle_scheduler_if;
  import filter_pkg::*;

  logic [3:0]        status_in;
  logic              status_valid_in;
  logic              float_full_in;
  logic              float_empty_in;
  logic              fault_clear_in;
  logic [DUTY_W-1:0] pump_a_duty_out;
  logic [DUTY_W-1:0] pump_b_duty_out;
  logic [2:0]        state_out;
  logic              fault_out;
  logic [1:0]        fault_code_out;
  logic [3:0]        cycle_count_out;

  modport master (
    output status_in, status_valid_in, float_full_in, float_empty_in, fault_clear_in,
    input  pump_a_duty_out, pump_b_duty_out, state_out, fault_out, fault_code_out,
           cycle_count_out
  );

  modport slave (
    input  status_in, status_valid_in, float_full_in, float_empty_in, fault_clear_in,
    output pump_a_duty_out, pump_b_duty_out, state_out, fault_out, fault_code_out,
           cycle_count_out
  );

endinterface

// File: rtl/filter_cycle_scheduler_duty_ramp.sv
// Soft-start ramp shared by both pumps: a prescaler that ticks every DIV
// clocks while enabled, and an accumulator that adds STEP per tick and
// saturates at MAX. The next-cycle level is exported so the owner can
// register its pump outputs in the same edge the ramp updates.
module duty_ramp
  import filter_pkg::*;
#(
  parameter logic [DUTY_W-1:0] STEP = 8'd10,
  parameter int                DIV  = 1000,
  parameter logic [DUTY_W-1:0] MAX  = 8'd230
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              enable,
  output logic [DUTY_W-1:0] level_next
);

  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0]  pre_reg;
  logic [PRE_W-1:0]  pre_next;
  logic [DUTY_W-1:0] level_reg;
  logic [DUTY_W:0]   sum;

  // Restart wins over counting; the sum is compared at 9 bits so it never wraps.
  always_comb begin
    pre_next   = pre_reg;
    level_next = level_reg;
    sum        = {1'b0, level_reg} + {1'b0, STEP};
    if (restart) begin
      pre_next   = '0;
      level_next = '0;
    end else if (enable) begin
      if (pre_reg == PRE_LAST) begin
        pre_next   = '0;
        level_next = (sum > {1'b0, MAX}) ? MAX : sum[DUTY_W-1:0];
      end else begin
        pre_next = pre_reg + 1'b1;
      end
    end
  end

  // Prescaler and accumulator state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_reg   <= '0;
      level_reg <= '0;
    end else begin
      pre_reg   <= pre_next;
      level_reg <= level_next;
    end
  end

endmodule

// File: rtl/filter_cycle_scheduler.sv
// Filtration-loop pump sequencer: IDLE/FILLING/RETURNING/DRAINING cycle with
// dead-time between pump handovers, per-state timeouts, a fill-cycle limit
// with lockout, and a latched fault state. All outputs come from registers.
module filter_cycle_scheduler
  import filter_pkg::*;
#(
  parameter logic [DUTY_W-1:0] RAMP_STEP     = 8'd10,
  parameter int                RAMP_DIV      = 1000,
  parameter logic [DUTY_W-1:0] DUTY_MAX      = 8'd230,
  parameter int                DEAD_CYCLES   = 16,
  parameter int                FILL_TIMEOUT  = 50_000_000,
  parameter int                DRAIN_TIMEOUT = 50_000_000,
  parameter int                MAX_CYCLES    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  filter_cycle_scheduler_if.slave  bus
);

  localparam int TIMER_W = 32;
  // Timeouts fire on the edge completing the Nth cycle, i.e. when the timer shows N-1.
  localparam logic [TIMER_W-1:0] FILL_LAST  = TIMER_W'(FILL_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] DRAIN_LAST = TIMER_W'(DRAIN_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] DEAD_LAST  = TIMER_W'(DEAD_CYCLES - 1);
  localparam logic [3:0]         MAX_CNT    = 4'(MAX_CYCLES);

  state_t            state_reg, state_next;
  state_t            target_reg, target_next;
  fault_t            code_reg, code_next;
  logic [3:0]        count_reg, count_next;
  logic              lockout_reg, lockout_next;
  logic [3:0]        status_reg;
  logic [TIMER_W-1:0] timer_reg;
  logic [DUTY_W-1:0] duty_a_reg, duty_b_reg;
  logic              fault_reg;

  logic              active;
  logic              conflict;
  logic              in_drain;
  logic              ramp_restart;
  logic              ramp_enable;
  logic [DUTY_W-1:0] ramp_next;

  assign active   = |status_reg;
  assign conflict = bus.float_full_in & bus.float_empty_in;
  assign in_drain = (state_reg == S_RETURNING) || (state_reg == S_DRAINING);

  // Next state, latched target/fault/count/lockout, and ramp control.
  always_comb begin
    state_next   = state_reg;
    target_next  = target_reg;
    code_next    = code_reg;
    count_next   = count_reg;
    lockout_next = active ? lockout_reg : 1'b0;
    if ((state_reg != S_FAULT) && conflict) begin
      state_next = S_FAULT;
      code_next  = F_CONFLICT;
    end else if ((state_reg == S_FILLING) && (timer_reg == FILL_LAST)) begin
      state_next = S_FAULT;
      code_next  = F_FILL;
    end else if (in_drain && (timer_reg == DRAIN_LAST)) begin
      state_next = S_FAULT;
      code_next  = F_DRAIN;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (active && !lockout_reg) begin
            state_next = S_FILLING;
            count_next = 4'd1;
          end
        end
        S_FILLING: begin
          if (bus.float_full_in) begin
            state_next  = S_DEADTIME;
            target_next = S_RETURNING;
          end
        end
        S_RETURNING: begin
          if (!active) begin
            state_next = S_DRAINING;
          end else if (bus.float_empty_in) begin
            if (count_reg < MAX_CNT) begin
              state_next  = S_DEADTIME;
              target_next = S_FILLING;
              count_next  = (count_reg == 4'hF) ? count_reg : count_reg + 4'd1;
            end else begin
              state_next   = S_IDLE;
              lockout_next = 1'b1;
            end
          end
        end
        S_DRAINING: begin
          if (bus.float_empty_in) state_next = S_IDLE;
        end
        S_DEADTIME: begin
          if (timer_reg == DEAD_LAST) state_next = target_reg;
        end
        S_FAULT: begin
          if (bus.fault_clear_in) begin
            state_next   = S_IDLE;
            code_next    = F_NONE;
            count_next   = 4'd0;
            lockout_next = 1'b0;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
    // Every state change zeroes the ramp except RETURNING->DRAINING, where pump B carries on.
    ramp_restart = (state_next != state_reg) &&
                   !((state_reg == S_RETURNING) && (state_next == S_DRAINING));
    ramp_enable  = is_pump_state(state_reg);
  end

  duty_ramp #(
    .STEP (RAMP_STEP),
    .DIV  (RAMP_DIV),
    .MAX  (DUTY_MAX)
  ) u_ramp (
    .clk        (clk),
    .rst        (rst),
    .restart    (ramp_restart),
    .enable     (ramp_enable),
    .level_next (ramp_next)
  );

  // Control state registers; status capture happens independently of the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      target_reg  <= S_IDLE;
      code_reg    <= F_NONE;
      count_reg   <= 4'd0;
      lockout_reg <= 1'b0;
      status_reg  <= 4'd0;
    end else begin
      state_reg   <= state_next;
      target_reg  <= target_next;
      code_reg    <= code_next;
      count_reg   <= count_next;
      lockout_reg <= lockout_next;
      if (bus.status_valid_in) status_reg <= bus.status_in;
    end
  end

  // State timer: cleared on each state change, saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || (state_next != state_reg)) begin
      timer_reg <= '0;
    end else if (timer_reg != '1) begin
      timer_reg <= timer_reg + 1'b1;
    end
  end

  // Registered pump duties and fault flag, steered by the upcoming state so a
  // pump is already at 0 on the cycle its state is left.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_a_reg <= '0;
      duty_b_reg <= '0;
      fault_reg  <= 1'b0;
    end else begin
      duty_a_reg <= (state_next == S_FILLING) ? ramp_next : '0;
      duty_b_reg <= ((state_next == S_RETURNING) || (state_next == S_DRAINING)) ?
                    ramp_next : '0;
      fault_reg  <= (state_next == S_FAULT);
    end
  end

  assign bus.pump_a_duty_out = duty_a_reg;
  assign bus.pump_b_duty_out = duty_b_reg;
  assign bus.state_out       = state_reg;
  assign bus.fault_out       = fault_reg;
  assign bus.fault_code_out  = code_reg;
  assign bus.cycle_count_out = count_reg;

endmodule

// File: tb/tb_filter_cycle_scheduler.sv
// Directed bench for the pump sequencer using small timing parameters.
module tb_filter_cycle_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  filter_cycle_scheduler_if bus();

  filter_cycle_scheduler #(
    .RAMP_STEP     (8'd100),
    .RAMP_DIV      (4),
    .DUTY_MAX      (8'd230),
    .DEAD_CYCLES   (3),
    .FILL_TIMEOUT  (50),
    .DRAIN_TIMEOUT (60),
    .MAX_CYCLES    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic status_pulse(input logic [3:0] v);
    bus.status_in       = v;
    bus.status_valid_in = 1'b1;
    tick();
    bus.status_valid_in = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while ((bus.state_out != s) && (n < budget));
    check_val(tag, bus.state_out, s);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_state"}, bus.state_out, 0);
    check_val({tag, "_duty_a"}, bus.pump_a_duty_out, 0);
    check_val({tag, "_duty_b"}, bus.pump_b_duty_out, 0);
    check_val({tag, "_fault"}, bus.fault_out, 0);
    check_val({tag, "_code"}, bus.fault_code_out, 0);
    check_val({tag, "_count"}, bus.cycle_count_out, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.status_in       = 4'd0;
    bus.status_valid_in = 1'b0;
    bus.float_full_in   = 1'b0;
    bus.float_empty_in  = 1'b0;
    bus.fault_clear_in  = 1'b0;

    // Reset held two clocks with sensors toggling.
    for (int i = 0; i < 2; i++) begin
      bus.float_full_in  = (i == 0);
      bus.float_empty_in = (i != 0);
      tick();
      check_idle_outputs("reset");
    end
    rst = 1'b0;
    bus.float_full_in  = 1'b0;
    bus.float_empty_in = 1'b0;
    tick();
    check_idle_outputs("post_reset");

    // Normal cycle: fill ramp, dead-time, return ramp, drain.
    status_pulse(4'b0001);
    check_val("latency_idle", bus.state_out, 0);
    tick();
    check_val("fill_entry_state", bus.state_out, 1);
    check_val("fill_entry_duty_a", bus.pump_a_duty_out, 0);
    check_val("fill_entry_count", bus.cycle_count_out, 1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 3)  check_val("ramp_a_3", bus.pump_a_duty_out, 0);
      if (k == 4)  check_val("ramp_a_4", bus.pump_a_duty_out, 100);
      if (k == 8)  check_val("ramp_a_8", bus.pump_a_duty_out, 200);
      if (k == 12) check_val("ramp_a_12", bus.pump_a_duty_out, 230);
      if (k == 16) check_val("ramp_a_16", bus.pump_a_duty_out, 230);
      if (k == 16) check_val("ramp_a_b_off", bus.pump_b_duty_out, 0);
    end
    bus.float_full_in = 1'b1;
    tick();
    bus.float_full_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_val("dead_state", bus.state_out, 4);
      check_val("dead_duty_a", bus.pump_a_duty_out, 0);
      check_val("dead_duty_b", bus.pump_b_duty_out, 0);
      tick();
    end
    check_val("ret_entry_state", bus.state_out, 2);
    check_val("ret_entry_duty_b", bus.pump_b_duty_out, 0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4)  check_val("ramp_b_4", bus.pump_b_duty_out, 100);
      if (k == 12) check_val("ramp_b_12", bus.pump_b_duty_out, 230);
    end
    status_pulse(4'b0000);
    tick();
    check_val("drain_state", bus.state_out, 3);
    check_val("drain_duty_b", bus.pump_b_duty_out, 230);
    check_val("drain_duty_a", bus.pump_a_duty_out, 0);
    bus.float_empty_in = 1'b1;
    tick();
    bus.float_empty_in = 1'b0;
    check_val("drain_done_state", bus.state_out, 0);
    check_val("drain_done_duty_b", bus.pump_b_duty_out, 0);

    // Fill timeout.
    status_pulse(4'b0001);
    tick();
    check_val("to_fill_state", bus.state_out, 1);
    for (int k = 0; k < 49; k++) tick();
    check_val("to_fill_49", bus.state_out, 1);
    tick();
    check_val("to_fill_fault_state", bus.state_out, 5);
    check_val("to_fill_fault_out", bus.fault_out, 1);
    check_val("to_fill_code", bus.fault_code_out, 1);
    check_val("to_fill_duty_a", bus.pump_a_duty_out, 0);
    bus.fault_clear_in = 1'b1;
    tick();
    bus.fault_clear_in = 1'b0;
    check_val("clear_state", bus.state_out, 0);
    check_val("clear_code", bus.fault_code_out, 0);
    check_val("clear_fault_out", bus.fault_out, 0);
    check_val("clear_count", bus.cycle_count_out, 0);
    tick();
    check_val("refill_state", bus.state_out, 1);
    check_val("refill_count", bus.cycle_count_out, 1);

    // Cycle limit with status held active.
    bus.float_full_in = 1'b1;
    tick();
    bus.float_full_in = 1'b0;
    wait_state("lim_ret1", 3'd2, 10);
    bus.float_empty_in = 1'b1;
    tick();
    bus.float_empty_in = 1'b0;
    check_val("lim_dead_state", bus.state_out, 4);
    check_val("lim_dead_count", bus.cycle_count_out, 2);
    wait_state("lim_fill2", 3'd1, 10);
    bus.float_full_in = 1'b1;
    tick();
    bus.float_full_in = 1'b0;
    wait_state("lim_ret2", 3'd2, 10);
    bus.float_empty_in = 1'b1;
    tick();
    bus.float_empty_in = 1'b0;
    check_val("lim_idle_state", bus.state_out, 0);
    check_val("lim_idle_count", bus.cycle_count_out, 2);
    for (int k = 0; k < 5; k++) tick();
    check_val("lim_lockout_hold", bus.state_out, 0);
    status_pulse(4'b0000);
    tick();
    check_val("lim_cleared_idle", bus.state_out, 0);
    status_pulse(4'b0010);
    tick();
    check_val("lim_restart_state", bus.state_out, 1);
    check_val("lim_restart_count", bus.cycle_count_out, 1);

    // Sensor conflict on the same edge as the return timeout.
    bus.float_full_in = 1'b1;
    tick();
    bus.float_full_in = 1'b0;
    wait_state("cf_ret", 3'd2, 10);
    for (int k = 0; k < 59; k++) tick();
    check_val("cf_ret_59", bus.state_out, 2);
    check_val("cf_ret_duty_b", bus.pump_b_duty_out, 230);
    bus.float_full_in  = 1'b1;
    bus.float_empty_in = 1'b1;
    tick();
    bus.float_full_in  = 1'b0;
    bus.float_empty_in = 1'b0;
    check_val("cf_state", bus.state_out, 5);
    check_val("cf_code", bus.fault_code_out, 3);
    check_val("cf_duty_b", bus.pump_b_duty_out, 0);

    // Reset in the middle of FILLING.
    bus.fault_clear_in = 1'b1;
    tick();
    bus.fault_clear_in = 1'b0;
    tick();
    check_val("rf_fill_state", bus.state_out, 1);
    for (int k = 0; k < 8; k++) tick();
    check_val("rf_duty_a", bus.pump_a_duty_out, 200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("rf_reset");
    for (int k = 0; k < 5; k++) begin
      tick();
      check_val("rf_stay_idle", bus.state_out, 0);
    end

    // Return timeout without conflict.
    status_pulse(4'b0001);
    tick();
    check_val("dt_fill_state", bus.state_out, 1);
    bus.float_full_in = 1'b1;
    tick();
    bus.float_full_in = 1'b0;
    wait_state("dt_ret", 3'd2, 10);
    for (int k = 0; k < 59; k++) tick();
    check_val("dt_ret_59", bus.state_out, 2);
    tick();
    check_val("dt_fault_state", bus.state_out, 5);
    check_val("dt_code", bus.fault_code_out, 2);
    check_val("dt_duty_b", bus.pump_b_duty_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/filter_cycle_scheduler.md
# filter_cycle_scheduler

Sequencing controller for the filtration loop's two pumps. It consumes the 4-bit strategic status word and the synchronized float sensors, and runs the IDLE/FILLING/RETURNING/DRAINING cycle. It drives 8-bit duty values to the two downstream PWM generators, adding soft-start ramping, pump dead-time, per-state timeouts, a cycle limit and a latched fault state.

## Interface
- `RAMP_STEP`, 8'd10, duty increment per ramp tick
- `RAMP_DIV`, 1000, clocks per ramp tick (≥1)
- `DUTY_MAX`, 8'd230, duty saturation ceiling (90 %)
- `DEAD_CYCLES`, 16, clocks with both pumps at 0 between pump handovers (≥1)
- `FILL_TIMEOUT`, 50_000_000, max clocks in FILLING
- `DRAIN_TIMEOUT`, 50_000_000, max clocks in RETURNING or DRAINING
- `MAX_CYCLES`, 8, fill cycles allowed per activation (1..15)
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock, reset is synchronous and active-high
- `status_in`  in  4  strategic status word from the handshake receiver
- `status_valid_in`  in  1  one-cycle pulse; capture `status_in`
- `float_full_in`  in  1  filter-full sensor, already synchronized
- `float_empty_in`  in  1  filter-empty sensor, already synchronized
- `fault_clear_in`  in  1  pulse; leave FAULT
- `pump_a_duty_out`  out  8  fill pump duty
- `pump_b_duty_out`  out  8  return pump duty
- `state_out`  out  3  current state encoding
- `fault_out`  out  1  high while in FAULT
- `fault_code_out`  out  2  01 fill timeout, 10 drain timeout, 11 sensor conflict; 00 when no fault
- `cycle_count_out`  out  4  fill entries since leaving IDLE, saturating

## Operation
- States and encodings: IDLE=0, FILLING=1, RETURNING=2, DRAINING=3, DEADTIME=4, FAULT=5.
- `status_reg` loads `status_in` on `status_valid_in`. `active` = |`status_reg`.
- IDLE to FILLING: requires `active` and `lockout` clear. On entry, `cycle_count` becomes 1.
- FILLING:
  - `float_full_in` → DEADTIME (target RETURNING).
  - Timeout → FAULT, code 01.
- RETURNING:
  - `active` clear → DRAINING. Pump B duty carries over; the ramp does not restart.
  - Else, `float_empty_in` with `cycle_count` < `MAX_CYCLES` → DEADTIME (target FILLING); `cycle_count`+1.
  - Else, `float_empty_in` with `cycle_count` = `MAX_CYCLES` → IDLE; set `lockout`.
  - Timeout → FAULT, code 10.
- DRAINING:
  - `float_empty_in` → IDLE.
  - Timeout → FAULT, code 10.
- DEADTIME: both duties 0. After `DEAD_CYCLES` clocks, go to the target state. The target ramp restarts at 0.
- FAULT: both duties 0. `fault_clear_in` → IDLE and clears `fault_code`, `cycle_count` and `lockout`. `status_reg` is kept.
- `lockout` also clears on any cycle where `status_reg` = 0.
- Sensor conflict: `float_full_in` and `float_empty_in` both high in any non-FAULT state → FAULT, code 11.
- Transition priority: `rst` > sensor conflict > timeout > normal transition.
- Ramp:
  - A single shared ramp is routed to pump A in FILLING and to pump B in RETURNING/DRAINING.
  - Value is 0 on state entry. Add `RAMP_STEP` every `RAMP_DIV` clocks.
  - If the sum would exceed `DUTY_MAX` (9-bit compare), load `DUTY_MAX`. The value never wraps.
- Pump A and pump B are never nonzero in the same cycle.

## Timing
- Reset values: duties 0, `state_out`=IDLE, `fault_out`=0, `fault_code_out`=00, `cycle_count_out`=0. Internal `status_reg`, `lockout`, timers and ramp are all 0.
- All outputs are registered.
  - Duty is 0 in the same cycle `state_out` changes away from a pump state.
  - Duty is 0 in the first cycle of a new pump state.
- Status latency:
  - `status_valid_in` at edge N → `status_reg` at N+1 → `state_out`=FILLING at N+2.
  - Sensor input high at edge N → new state at N+1.
- State timer resets on every state change. A timeout fires on the edge that completes the `FILL_TIMEOUT`th (or `DRAIN_TIMEOUT`th) cycle in the state.
- `rst` mid-operation: next edge forces reset values. No drain sequence runs.

## Structure
- Shared package `filter_pkg` holds:
  - `state_t` (3-bit enum)
  - `fault_t` (2-bit codes)
  - `DUTY_W`=8
- Sub-module `duty_ramp`:
  - Inputs: `restart`, `enable`.
  - Contains the prescaler counter and the saturating accumulator.
  - One instance; output muxed by state.

## Test plan
Bench parameters: `RAMP_DIV`=4, `RAMP_STEP`=100, `DUTY_MAX`=230, `DEAD_CYCLES`=3, `FILL_TIMEOUT`=50, `DRAIN_TIMEOUT`=60, `MAX_CYCLES`=2.

- Reset: hold `rst` 2 clocks with sensors toggling → all outputs at reset values. `state_out`=0 the cycle after release.
- Normal cycle:
  - Pulse `status` 0001 → FILLING 2 clocks later.
  - `pump_a_duty_out` 0 → 100 (+4) → 200 (+8) → 230 (+12), then holds.
  - `float_full_in` → DEADTIME for 3 clocks with both duties 0 → RETURNING, pump B ramps.
  - `status` 0000 → DRAINING with B duty unchanged.
  - `float_empty_in` → IDLE.
- Fill timeout: `status` 0001, `float_full_in` never asserted → FAULT after 50 FILLING clocks, code 01, duties 0. `fault_clear_in` → IDLE, then FILLING 1 clock later.
- Cycle limit: `status` held 0001, full/empty alternated → after the 2nd RETURNING empty, IDLE with count 2 and stays IDLE. `status` 0000 then 0010 → FILLING with count 1.
- Sensor conflict: both sensors high in RETURNING on the clock its timeout also expires → FAULT, code 11 (not 10), B duty 0 next cycle.
- Reset mid-FILLING at duty 200 → next cycle duties 0, IDLE, `status_reg` 0. No FILLING until a new status pulse.
